// File: rtl/dp_ram_fifo_ctrl_pkg.sv
// rtl/dp_ram_fifo_ctrl_pkg.sv - shared constants, width helpers and flag bundle for the FIFO controller
// Purpose: depth / pointer width helpers and the status flag bundle type.
// Ports: none (package).
package dp_ram_fifo_pkg;

    localparam int DEFAULT_RAM_WIDTH = 8;
    localparam int DEFAULT_ADDR_SIZE = 4;

    function automatic int fifo_depth(input int addr_size);
        return 1 << addr_size;
    endfunction

    // One extra wrap bit so that wr_ptr - rd_ptr spans 0..depth inclusive.
    function automatic int ptr_width(input int addr_size);
        return addr_size + 1;
    endfunction

    // The count spans 0..depth, so it needs the same width as a pointer.
    function automatic int count_width(input int addr_size);
        return addr_size + 1;
    endfunction

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_flags_t;

endpackage

// File: rtl/dp_ram_fifo_ctrl_if.sv
// rtl/dp_ram_fifo_ctrl_if.sv - producer/consumer and RAM-side signal bundle of the FIFO controller
// Purpose: groups every non-clock/reset port of dp_ram_fifo_ctrl.
// Ports: slave = controller view, master = environment view (producer, consumer, RAM).
interface dp_ram_fifo_ctrl_if #(
    parameter int ram_width = 8,
    parameter int addr_size = 4
);
    logic                 wr_req;
    logic [ram_width-1:0] wr_data;
    logic                 rd_req;
    logic                 clr_err;
    logic                 ram_write_en;
    logic [addr_size-1:0] ram_wr_addr;
    logic [ram_width-1:0] ram_data_in;
    logic                 ram_read_en;
    logic [addr_size-1:0] ram_rd_addr;
    logic [ram_width-1:0] ram_data_out;
    logic [ram_width-1:0] rd_data;
    logic                 rd_valid;
    logic                 full;
    logic                 empty;
    logic                 almost_full;
    logic                 almost_empty;
    logic [addr_size:0]   count;
    logic                 overflow;
    logic                 underflow;

    modport slave (
        input  wr_req, wr_data, rd_req, clr_err, ram_data_out,
        output ram_write_en, ram_wr_addr, ram_data_in, ram_read_en, ram_rd_addr,
               rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport master (
        output wr_req, wr_data, rd_req, clr_err, ram_data_out,
        input  ram_write_en, ram_wr_addr, ram_data_in, ram_read_en, ram_rd_addr,
               rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

endinterface

// File: rtl/dp_ram_2p.sv
// rtl/dp_ram_2p.sv - two-port RAM, one write port and one registered read port
// Purpose: storage used behind the FIFO controller; read data appears one cycle after read_en.
// Ports: clk, reset (clears the read register only), write_en/wr_addr/data_in,
//        read_en/rd_addr, data_out.
module dp_ram_2p #(
    parameter int width     = 8,
    parameter int addr_size = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 write_en,
    input  logic [addr_size-1:0] wr_addr,
    input  logic [width-1:0]     data_in,
    input  logic                 read_en,
    input  logic [addr_size-1:0] rd_addr,
    output logic [width-1:0]     data_out
);

    logic [width-1:0] mem [0:(1<<addr_size)-1];

    always_ff @(posedge clk) begin
        if (write_en) begin
            mem[wr_addr] <= data_in;
        end
    end

    // Same-address read and write in one cycle returns the old word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out <= '0;
        end else if (read_en) begin
            data_out <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/dp_ram_fifo_ctrl_ptr_ctrl.sv
// rtl/dp_ram_fifo_ctrl_ptr_ctrl.sv - pointer, occupancy and status flag logic of the FIFO controller
// Purpose: accepts/refuses requests, advances wrap-bit pointers, registers count and flags.
// Ports: clk, reset, wr_req, rd_req in; wr_acc, rd_acc, wr_addr, rd_addr, count,
//        full, empty, almost_full, almost_empty out.
module fifo_ptr_ctrl
    import dp_ram_fifo_pkg::*;
#(
    parameter int addr_size    = 4,
    parameter int afull_level  = 14,
    parameter int aempty_level = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_req,
    input  logic                 rd_req,
    output logic                 wr_acc,
    output logic                 rd_acc,
    output logic [addr_size-1:0] wr_addr,
    output logic [addr_size-1:0] rd_addr,
    output logic [addr_size:0]   count,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty
);

    localparam int pw = ptr_width(addr_size);
    localparam logic [pw-1:0] depth_c  = pw'(fifo_depth(addr_size));
    localparam logic [pw-1:0] afull_c  = pw'(afull_level);
    localparam logic [pw-1:0] aempty_c = pw'(aempty_level);

    logic [pw-1:0] wr_ptr, rd_ptr;
    logic [pw-1:0] wr_ptr_nxt, rd_ptr_nxt, count_nxt;

    assign rd_acc = rd_req & ~empty;
    // A full FIFO still takes a write when a read frees the slot in the same cycle.
    assign wr_acc = wr_req & (~full | rd_acc);

    assign wr_ptr_nxt = wr_ptr + pw'(wr_acc);
    assign rd_ptr_nxt = rd_ptr + pw'(rd_acc);
    // The wrap bit lets the plain pointer difference distinguish full from empty.
    assign count_nxt  = wr_ptr_nxt - rd_ptr_nxt;

    assign wr_addr = wr_ptr[addr_size-1:0];
    assign rd_addr = rd_ptr[addr_size-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            wr_ptr       <= wr_ptr_nxt;
            rd_ptr       <= rd_ptr_nxt;
            count        <= count_nxt;
            full         <= (count_nxt == depth_c);
            empty        <= (count_nxt == '0);
            almost_full  <= (count_nxt >= afull_c);
            almost_empty <= (count_nxt <= aempty_c);
        end
    end

endmodule

// File: rtl/dp_ram_fifo_ctrl.sv
// rtl/dp_ram_fifo_ctrl.sv - FIFO controller sequencing an external two-port RAM as a circular buffer
// Purpose: maps accepted requests onto RAM enables/addresses, forwards read data with a
//          valid strobe one cycle later, and keeps sticky overflow/underflow flags.
// Ports: clk, reset (async, active high); bus (dp_ram_fifo_ctrl_if.slave) carrying the
//        producer, consumer, RAM and status signals.
module dp_ram_fifo_ctrl
    import dp_ram_fifo_pkg::*;
#(
    parameter int ram_width    = 8,
    parameter int addr_size    = 4,
    parameter int afull_level  = 14,
    parameter int aempty_level = 2
) (
    input  logic               clk,
    input  logic               reset,
    dp_ram_fifo_ctrl_if.slave  bus
);

    logic                 wr_acc, rd_acc;
    logic [addr_size-1:0] wr_addr, rd_addr;
    logic [addr_size:0]   count;
    logic                 full, empty, almost_full, almost_empty;
    logic                 rd_valid_q, overflow_q, underflow_q;
    fifo_flags_t          flags;

    fifo_ptr_ctrl #(
        .addr_size    (addr_size),
        .afull_level  (afull_level),
        .aempty_level (aempty_level)
    ) u_ptr_ctrl (
        .clk          (clk),
        .reset        (reset),
        .wr_req       (bus.wr_req),
        .rd_req       (bus.rd_req),
        .wr_acc       (wr_acc),
        .rd_acc       (rd_acc),
        .wr_addr      (wr_addr),
        .rd_addr      (rd_addr),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
    );

    // A new error event outranks a simultaneous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_acc;
            if (bus.wr_req && !wr_acc) begin
                overflow_q <= 1'b1;
            end else if (bus.clr_err) begin
                overflow_q <= 1'b0;
            end
            if (bus.rd_req && empty) begin
                underflow_q <= 1'b1;
            end else if (bus.clr_err) begin
                underflow_q <= 1'b0;
            end
        end
    end

    assign flags = '{full: full, empty: empty, almost_full: almost_full,
                     almost_empty: almost_empty, overflow: overflow_q,
                     underflow: underflow_q};

    assign bus.ram_write_en = wr_acc;
    assign bus.ram_wr_addr  = wr_addr;
    assign bus.ram_data_in  = bus.wr_data[ram_width-1:0];
    assign bus.ram_read_en  = rd_acc;
    assign bus.ram_rd_addr  = rd_addr;
    assign bus.rd_data      = bus.ram_data_out;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.count        = count;
    assign bus.full         = flags.full;
    assign bus.empty        = flags.empty;
    assign bus.almost_full  = flags.almost_full;
    assign bus.almost_empty = flags.almost_empty;
    assign bus.overflow     = flags.overflow;
    assign bus.underflow    = flags.underflow;

endmodule

// File: tb/tb_dp_ram_fifo_ctrl.sv
// tb/tb_dp_ram_fifo_ctrl.sv - self-checking bench for dp_ram_fifo_ctrl with a queue reference model
module tb_dp_ram_fifo_ctrl;

    localparam int W      = 8;
    localparam int A      = 4;
    localparam int DEPTH  = 16;
    localparam int AFULL  = 14;
    localparam int AEMPTY = 2;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    dp_ram_fifo_ctrl_if #(.ram_width(W), .addr_size(A)) bus ();

    dp_ram_fifo_ctrl #(
        .ram_width    (W),
        .addr_size    (A),
        .afull_level  (AFULL),
        .aempty_level (AEMPTY)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    dp_ram_2p #(.width(W), .addr_size(A)) u_ram (
        .clk      (clk),
        .reset    (1'b0),
        .write_en (bus.ram_write_en),
        .wr_addr  (bus.ram_wr_addr),
        .data_in  (bus.ram_data_in),
        .read_en  (bus.ram_read_en),
        .rd_addr  (bus.ram_rd_addr),
        .data_out (bus.ram_data_out)
    );

    // Reference model: contents as a queue, accepted-transfer totals, error flags,
    // and the word expected on rd_data in the cycle after an accepted read.
    logic [W-1:0] q[$];
    int           n_wr, n_rd;
    bit           m_ovf, m_unf, m_valid;
    logic [W-1:0] m_rdata;
    int           n_chk  = 0;
    int           n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        n_wr    = 0;
        n_rd    = 0;
        m_ovf   = 0;
        m_unf   = 0;
        m_valid = 0;
        m_rdata = '0;
    endtask

    task automatic check_state();
        int sz;
        sz = q.size();
        chk("count",        32'(bus.count),        32'(sz));
        chk("full",         32'(bus.full),         32'(sz == DEPTH));
        chk("empty",        32'(bus.empty),        32'(sz == 0));
        chk("almost_full",  32'(bus.almost_full),  32'(sz >= AFULL));
        chk("almost_empty", 32'(bus.almost_empty), 32'(sz <= AEMPTY));
        chk("overflow",     32'(bus.overflow),     32'(m_ovf));
        chk("underflow",    32'(bus.underflow),    32'(m_unf));
        chk("rd_valid",     32'(bus.rd_valid),     32'(m_valid));
        if (m_valid) chk("rd_data", 32'(bus.rd_data), 32'(m_rdata));
    endtask

    // One clock cycle: drive inputs, check at the falling edge, then advance the model.
    task automatic cycle(input bit wr, input logic [W-1:0] wd, input bit rd, input bit clr);
        bit exp_rd, exp_wr, was_empty;
        bus.wr_req  = wr;
        bus.wr_data = wd;
        bus.rd_req  = rd;
        bus.clr_err = clr;
        @(negedge clk);
        check_state();
        was_empty = (q.size() == 0);
        exp_rd    = rd && !was_empty;
        exp_wr    = wr && (q.size() < DEPTH || exp_rd);
        chk("ram_read_en",  32'(bus.ram_read_en),  32'(exp_rd));
        chk("ram_write_en", 32'(bus.ram_write_en), 32'(exp_wr));
        if (exp_wr) begin
            chk("ram_wr_addr", 32'(bus.ram_wr_addr), 32'(n_wr % DEPTH));
            chk("ram_data_in", 32'(bus.ram_data_in), 32'(wd));
        end
        if (exp_rd) chk("ram_rd_addr", 32'(bus.ram_rd_addr), 32'(n_rd % DEPTH));
        @(posedge clk);
        #1;
        m_valid = exp_rd;
        if (exp_rd) begin
            m_rdata = q.pop_front();
            n_rd++;
        end
        if (exp_wr) begin
            q.push_back(wd);
            n_wr++;
        end
        if (wr && !exp_wr) m_ovf = 1;
        else if (clr)      m_ovf = 0;
        if (rd && was_empty) m_unf = 1;
        else if (clr)        m_unf = 0;
    endtask

    task automatic idle();
        cycle(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 1 && q.size() != 0; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        idle();
    endtask

    initial begin
        reset       = 1'b1;
        bus.wr_req  = 1'b0;
        bus.wr_data = '0;
        bus.rd_req  = 1'b0;
        bus.clr_err = 1'b0;
        model_reset();

        // Reset state
        @(negedge clk);
        check_state();
        @(posedge clk);
        #1 reset = 1'b0;

        // Four writes then four reads
        for (int i = 0; i < 4; i++) cycle(1'b1, W'(8'h11 + i), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        idle();

        // Fill to full, overflow on the 17th write, then clear
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, W'(i), 1'b0, 1'b0);
        cycle(1'b1, 8'h99, 1'b0, 1'b0);
        idle();
        cycle(1'b0, '0, 1'b0, 1'b1);
        idle();

        // Simultaneous write and read while full, then drain
        cycle(1'b1, 8'hAA, 1'b1, 1'b0);
        drain();

        // Simultaneous write and read while empty
        cycle(1'b1, 8'h55, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        idle();
        cycle(1'b0, '0, 1'b0, 1'b1);
        idle();

        // Error set and clear in the same cycle: the set wins
        cycle(1'b0, '0, 1'b1, 1'b1);
        idle();
        cycle(1'b0, '0, 1'b0, 1'b1);

        // Randomised interleaved traffic forcing pointer wrap
        for (int i = 0; i < 40; i++) cycle(1'b1, W'($urandom), ($urandom % 3) != 0, 1'b0);
        for (int i = 0; i < 40; i++)
            cycle(($urandom % 2) != 0, W'($urandom), ($urandom % 2) != 0, ($urandom % 8) == 0);
        drain();

        // Asynchronous reset with count = 7, a read in flight and underflow set
        cycle(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b1, W'($urandom), 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        chk("pre_reset_count", 32'(bus.count), 32'd7);
        chk("pre_reset_valid", 32'(bus.rd_valid), 32'd1);
        bus.rd_req = 1'b0;
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_state();
        @(negedge clk);
        check_state();
        @(posedge clk);
        #1 reset = 1'b0;

        // Operation resumes from address 0 after reset
        cycle(1'b1, 8'h3C, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
